multicycle_control_fsm: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 65 ++++++
 rtl/multicycle_control_fsm_ctrl_output_decode.sv | 123 ++++++++++++
 rtl/multicycle_control_fsm.sv | 151 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared types and constants for the multicycle MIPS main
//               controller: state encoding, opcodes, ALU codes and the
//               control word that drives the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Controller states, 4-bit encoding exposed on the debug port
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RX     = 4'd6,
        RWB    = 4'd7,
        IX     = 4'd8,
        IWB    = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_e;

    // Opcodes the controller distinguishes on its own
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd8;

    // Full set of datapath enables and selects for one cycle
    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       mem_timeout;
    } ctrl_word_t;

    // States that wait on the memory ready handshake and can time out
    function automatic logic is_stall_state(input state_e s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_control_fsm_ctrl_output_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_output_decode
// Description : Combinational state-to-control-word decoder. Mostly Moore;
//               the memory handshake, branch zero flag and stall limit only
//               qualify the write strobes and pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic       run_i,          // low while reset is asserted
    input  logic       mem_ready_i,
    input  logic       zero_i,
    input  logic [5:0] opcode_i,
    input  logic [3:0] dec_alu_control_i,
    input  logic [1:0] mux4selector_i,
    input  logic       at_limit_i,     // wait counter equals the stall limit
    input  logic       suppress_pc_i,  // hold PC on the first fetch after reset
    output ctrl_word_t ctrl_o
);

    // Decode the control word for the current state
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.iord        = 1'b0;
                ctrl_o.mem_read    = 1'b1;
                ctrl_o.alu_src_a   = 1'b0;
                ctrl_o.alu_src_b   = 2'd1;
                ctrl_o.alu_control = ALU_ADD;
                ctrl_o.pc_src      = 2'd0;
                if (mem_ready_i) begin
                    ctrl_o.ir_write = 1'b1;
                    ctrl_o.pc_write = ~suppress_pc_i;
                end
            end
            DECODE: begin
                // Branch target is precomputed here as PC+4 + (imm<<2)
                ctrl_o.alu_src_a   = 1'b0;
                ctrl_o.alu_src_b   = 2'd3;
                ctrl_o.alu_control = ALU_ADD;
            end
            MEMADR: begin
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_src_b   = 2'd2;
                ctrl_o.alu_control = ALU_ADD;
            end
            MEMRD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
                if (mem_ready_i) begin
                    ctrl_o.instr_done = 1'b1;
                end
            end
            RX: begin
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_src_b   = mux4selector_i;
                ctrl_o.alu_control = dec_alu_control_i;
            end
            RWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            IX: begin
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_src_b   = 2'd2;
                ctrl_o.alu_control = dec_alu_control_i;
            end
            IWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_src_b   = 2'd0;
                ctrl_o.alu_control = ALU_SUB;
                ctrl_o.pc_src      = 2'd1;
                ctrl_o.instr_done  = 1'b1;
                ctrl_o.pc_write    = ((opcode_i == OP_BEQ) &&  zero_i) ||
                                     ((opcode_i == OP_BNE) && ~zero_i);
            end
            JUMP: begin
                ctrl_o.pc_src     = 2'd2;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase

        // Stall abort only when the access has not completed this cycle
        ctrl_o.mem_timeout = is_stall_state(state_i) && !mem_ready_i && at_limit_i;

        // No architectural side effects while reset is held
        if (!run_i) begin
            ctrl_o.ir_write    = 1'b0;
            ctrl_o.pc_write    = 1'b0;
            ctrl_o.reg_write   = 1'b0;
            ctrl_o.mem_write   = 1'b0;
            ctrl_o.instr_done  = 1'b0;
            ctrl_o.mem_timeout = 1'b0;
        end
    end

endmodule : ctrl_output_decode
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Multicycle MIPS main controller. Steps each instruction
//               through fetch/decode/execute/memory/writeback, stalls on
//               the memory ready handshake and aborts stuck accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT     = 15,    // must fit the 4-bit wait counter
    parameter bit RESET_PC_WRITE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       flag_R_type,
    input  logic       flag_I_type,
    input  logic       flag_lw,
    input  logic       flag_sw,
    input  logic [3:0] dec_alu_control,
    input  logic [1:0] mux4selector,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam logic [3:0] c_WAIT_LIMIT = 4'(WAIT_LIMIT);

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       first_fetch_q, first_fetch_d;
    logic       at_limit;
    logic       suppress_pc;
    ctrl_word_t ctrl;

    assign at_limit    = (wait_cnt_q == c_WAIT_LIMIT);
    assign suppress_pc = RESET_PC_WRITE && first_fetch_q;

    ctrl_output_decode u_decode (
        .state_i           (state_q),
        .run_i             (reset),
        .mem_ready_i       (mem_ready),
        .zero_i            (zero),
        .opcode_i          (opcode),
        .dec_alu_control_i (dec_alu_control),
        .mux4selector_i    (mux4selector),
        .at_limit_i        (at_limit),
        .suppress_pc_i     (suppress_pc),
        .ctrl_o            (ctrl)
    );

    // Next-state, wait counter and first-fetch tracking
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q + 4'd1;
        first_fetch_d = first_fetch_q;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    state_d       = DECODE;
                    first_fetch_d = 1'b0;
                end
            end
            DECODE: begin
                if (flag_lw || flag_sw) begin
                    state_d = MEMADR;
                end else if (flag_R_type) begin
                    state_d = RX;
                end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
                    state_d = BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = JUMP;
                end else if (flag_I_type) begin
                    state_d = IX;
                end else begin
                    // Unrecognised instruction: drop it and refetch
                    state_d = FETCH;
                end
            end
            MEMADR:  state_d = flag_lw ? MEMRD : MEMWR;
            MEMRD: begin
                if (mem_ready)     state_d = MEMWB;
                else if (at_limit) state_d = FETCH;
            end
            MEMWR: begin
                if (mem_ready || at_limit) state_d = FETCH;
            end
            RX:      state_d = RWB;
            IX:      state_d = IWB;
            MEMWB,
            RWB,
            IWB,
            BRANCH,
            JUMP:    state_d = FETCH;
            default: state_d = FETCH;
        endcase

        // Counter measures time in the current state; an abort restarts it
        // even when the next state is FETCH again
        if ((state_d != state_q) || ctrl.mem_timeout) begin
            wait_cnt_d = 4'd0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FETCH;
            wait_cnt_q    <= 4'd0;
            first_fetch_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            first_fetch_q <= first_fetch_d;
        end
    end

    assign ir_write    = ctrl.ir_write;
    assign pc_write    = ctrl.pc_write;
    assign iord        = ctrl.iord;
    assign mem_read    = ctrl.mem_read;
    assign mem_write   = ctrl.mem_write;
    assign reg_write   = ctrl.reg_write;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign reg_dst     = ctrl.reg_dst;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_control = ctrl.alu_control;
    assign pc_src      = ctrl.pc_src;
    assign instr_done  = ctrl.instr_done;
    assign mem_timeout = ctrl.mem_timeout;
    assign state       = state_q;

endmodule : multicycle_control_fsm
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Self-checking bench for the multicycle controller. Each
//               instruction is expanded into its expected state walk and
//               per-instruction strobe totals, then compared against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       flag_R_type, flag_I_type, flag_lw, flag_sw;
    logic [3:0] dec_alu_control;
    logic [1:0] mux4selector;
    logic       zero, mem_ready;
    logic       ir_write, pc_write, iord, mem_read, mem_write, reg_write;
    logic       mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_control, state;
    logic       instr_done, mem_timeout;

    int vecs = 0;
    int errs = 0;
    logic [3:0] alu_codes [5] = '{4'd2, 4'd3, 4'd5, 4'd6, 4'd8};

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .flag_R_type(flag_R_type), .flag_I_type(flag_I_type),
        .flag_lw(flag_lw), .flag_sw(flag_sw),
        .dec_alu_control(dec_alu_control), .mux4selector(mux4selector),
        .zero(zero), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src),
        .instr_done(instr_done), .mem_timeout(mem_timeout), .state(state)
    );

    // Run one instruction: sf fetch stalls, sm memory stalls, branch zero z,
    // mem_to = memory phase is abandoned after 16 stall cycles.
    task automatic run_instr(input int kind, input int sf, input int sm,
                             input bit z, input bit mem_to);
        int exp_st[$];
        int rdy[$];
        int n_ir = 0, n_pcw = 0, n_rw = 0, n_mw = 0, n_done = 0, n_to = 0;
        int done_at = -1, wb_dst = -1, wb_m2r = -1, br_src = -1;
        int exp_rw, exp_mw, exp_pcw;

        opcode = 6'h00; flag_R_type = 0; flag_I_type = 0; flag_lw = 0; flag_sw = 0;
        case (kind)
            K_R:   flag_R_type = 1;
            K_I:   begin opcode = 6'h08; flag_I_type = 1; end
            K_LW:  begin opcode = 6'h23; flag_I_type = 1; flag_lw = 1; end
            K_SW:  begin opcode = 6'h2B; flag_I_type = 1; flag_sw = 1; end
            K_BEQ: begin opcode = 6'h04; flag_I_type = 1; end
            K_BNE: begin opcode = 6'h05; flag_I_type = 1; end
            default: opcode = 6'h02;
        endcase
        dec_alu_control = alu_codes[$urandom_range(0, 4)];
        mux4selector    = 2'($urandom_range(0, 3));
        zero            = z;

        // Expected walk: rdy 0 = hold low, 1 = complete, 2 = don't care
        for (int i = 0; i < sf; i++) begin exp_st.push_back(0); rdy.push_back(0); end
        exp_st.push_back(0); rdy.push_back(1);
        exp_st.push_back(1); rdy.push_back(2);
        case (kind)
            K_R: begin exp_st.push_back(6); rdy.push_back(2); exp_st.push_back(7); rdy.push_back(2); end
            K_I: begin exp_st.push_back(8); rdy.push_back(2); exp_st.push_back(9); rdy.push_back(2); end
            K_LW: begin
                exp_st.push_back(2); rdy.push_back(2);
                for (int i = 0; i < sm; i++) begin exp_st.push_back(3); rdy.push_back(0); end
                if (!mem_to) begin
                    exp_st.push_back(3); rdy.push_back(1);
                    exp_st.push_back(4); rdy.push_back(2);
                end
            end
            K_SW: begin
                exp_st.push_back(2); rdy.push_back(2);
                for (int i = 0; i < sm; i++) begin exp_st.push_back(5); rdy.push_back(0); end
                if (!mem_to) begin exp_st.push_back(5); rdy.push_back(1); end
            end
            K_BEQ, K_BNE: begin exp_st.push_back(10); rdy.push_back(2); end
            default: begin exp_st.push_back(11); rdy.push_back(2); end
        endcase

        for (int i = 0; i < exp_st.size(); i++) begin
            mem_ready = (rdy[i] == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy[i]);
            #1;
            vecs++;
            if (state !== 4'(exp_st[i])) begin
                errs++;
                $display("FAIL state k%0d c%0d: got %0d expected %0d", kind, i, state, exp_st[i]);
            end
            if (exp_st[i] == 6 || exp_st[i] == 8) begin
                vecs++;
                if (alu_control !== dec_alu_control ||
                    alu_src_b !== ((exp_st[i] == 6) ? mux4selector : 2'd2)) begin
                    errs++;
                    $display("FAIL exec_alu k%0d: got ctl %0d srcb %0d expected ctl %0d srcb %0d",
                             kind, alu_control, alu_src_b, dec_alu_control,
                             (exp_st[i] == 6) ? mux4selector : 2'd2);
                end
            end
            if (exp_st[i] == 10) begin
                vecs++;
                if (alu_control !== 4'd3 || pc_src !== 2'd1) begin
                    errs++;
                    $display("FAIL branch_sel: got ctl %0d pc_src %0d expected 3 1", alu_control, pc_src);
                end
            end
            n_ir  += int'(ir_write);
            n_pcw += int'(pc_write);
            n_mw  += int'(mem_write);
            n_to  += int'(mem_timeout);
            if (reg_write) begin n_rw++; wb_dst = int'(reg_dst); wb_m2r = int'(mem_to_reg); end
            if (instr_done) begin n_done++; done_at = i; end
            if (pc_write && exp_st[i] != 0) br_src = int'(pc_src);
            @(negedge clk);
        end

        exp_rw  = ((kind == K_R || kind == K_I || kind == K_LW) && !mem_to) ? 1 : 0;
        exp_mw  = (kind == K_SW) ? sm + (mem_to ? 0 : 1) : 0;
        exp_pcw = 1 + ((kind == K_J) ? 1 : 0) + ((kind == K_BEQ && z) ? 1 : 0) +
                  ((kind == K_BNE && !z) ? 1 : 0);

        vecs++;
        if (n_ir !== 1) begin errs++; $display("FAIL ir_write_count k%0d: got %0d expected 1", kind, n_ir); end
        vecs++;
        if (n_pcw !== exp_pcw) begin errs++; $display("FAIL pc_write_count k%0d: got %0d expected %0d", kind, n_pcw, exp_pcw); end
        vecs++;
        if (n_rw !== exp_rw) begin errs++; $display("FAIL reg_write_count k%0d: got %0d expected %0d", kind, n_rw, exp_rw); end
        vecs++;
        if (n_mw !== exp_mw) begin errs++; $display("FAIL mem_write_cycles k%0d: got %0d expected %0d", kind, n_mw, exp_mw); end
        vecs++;
        if (n_to !== int'(mem_to)) begin errs++; $display("FAIL timeout_count k%0d: got %0d expected %0d", kind, n_to, mem_to); end
        vecs++;
        if (n_done !== (mem_to ? 0 : 1) || (!mem_to && done_at !== exp_st.size() - 1)) begin
            errs++;
            $display("FAIL instr_done k%0d: got %0d pulses at %0d expected %0d at %0d",
                     kind, n_done, done_at, mem_to ? 0 : 1, exp_st.size() - 1);
        end
        if (exp_rw == 1) begin
            vecs++;
            if (wb_dst !== ((kind == K_R) ? 1 : 0) || wb_m2r !== ((kind == K_LW) ? 1 : 0)) begin
                errs++;
                $display("FAIL writeback_sel k%0d: got dst %0d m2r %0d expected %0d %0d",
                         kind, wb_dst, wb_m2r, (kind == K_R) ? 1 : 0, (kind == K_LW) ? 1 : 0);
            end
        end
        if (exp_pcw == 2) begin
            vecs++;
            if (br_src !== ((kind == K_J) ? 2 : 1)) begin
                errs++;
                $display("FAIL pc_src k%0d: got %0d expected %0d", kind, br_src, (kind == K_J) ? 2 : 1);
            end
        end
    endtask

    // Reset-state outputs while reset is held, even with mem_ready high
    task automatic check_reset_outputs(input string tag);
        vecs++;
        if (state !== 4'd0 || mem_read !== 1'b1 || alu_src_b !== 2'd1 || pc_write !== 1'b0 ||
            ir_write !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0 ||
            instr_done !== 1'b0 || mem_timeout !== 1'b0) begin
            errs++;
            $display("FAIL %s: got st %0d rd %0d srcb %0d pcw %0d irw %0d rw %0d mw %0d expected 0 1 1 0 0 0 0",
                     tag, state, mem_read, alu_src_b, pc_write, ir_write, reg_write, mem_write);
        end
    endtask

    task automatic test_reset();
        reset = 0; mem_ready = 1; zero = 0; opcode = 0; flag_R_type = 0; flag_I_type = 0;
        flag_lw = 0; flag_sw = 0; dec_alu_control = 0; mux4selector = 0;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset_mid_memrd();
        opcode = 6'h23; flag_lw = 1; flag_I_type = 1; flag_R_type = 0; flag_sw = 0;
        mem_ready = 1; @(negedge clk);   // FETCH completes
        mem_ready = 0; @(negedge clk);   // DECODE
        @(negedge clk);                  // MEMADR
        @(negedge clk);                  // MEMRD, stalling
        #1;
        vecs++;
        if (state !== 4'd3) begin errs++; $display("FAIL memrd_entry: got %0d expected 3", state); end
        #2 reset = 0; mem_ready = 1;
        #1 check_reset_outputs("async_reset_memrd");
        @(negedge clk);
        #1 check_reset_outputs("reset_held_edge");
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_add();
        run_instr(K_R, 0, 0, 0, 0);
    endtask

    task automatic test_lw_stall();
        run_instr(K_LW, 0, 3, 0, 0);
        run_instr(K_SW, 0, 2, 0, 0);
    endtask

    task automatic test_branch_jump();
        run_instr(K_BEQ, 0, 0, 1, 0);
        run_instr(K_BEQ, 0, 0, 0, 0);
        run_instr(K_BNE, 0, 0, 0, 0);
        run_instr(K_BNE, 0, 0, 1, 0);
        run_instr(K_J,   0, 0, 0, 0);
        run_instr(K_I,   0, 0, 0, 0);
    endtask

    task automatic test_fetch_timeout();
        mem_ready = 0;
        for (int i = 0; i < 32; i++) begin
            #1;
            vecs++;
            if (mem_timeout !== ((i == 15 || i == 31) ? 1'b1 : 1'b0) || ir_write !== 1'b0 ||
                pc_write !== 1'b0 || state !== 4'd0) begin
                errs++;
                $display("FAIL fetch_timeout c%0d: got to %0d irw %0d pcw %0d st %0d expected %0d 0 0 0",
                         i, mem_timeout, ir_write, pc_write, state, (i == 15 || i == 31) ? 1 : 0);
            end
            @(negedge clk);
        end
        run_instr(K_R, 2, 0, 0, 0);
    endtask

    task automatic test_mem_timeout();
        run_instr(K_LW, 0, 16, 0, 1);
        run_instr(K_SW, 1, 16, 0, 1);
        // Completion on the limit cycle wins over the abort
        run_instr(K_R,  15, 0, 0, 0);
        run_instr(K_LW, 0, 15, 0, 0);
        run_instr(K_SW, 15, 15, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            int k  = $urandom_range(0, 6);
            int sf = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            int sm = $urandom_range(0, 5);
            run_instr(k, sf, sm, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_branch_jump();
        test_fetch_timeout();
        test_mem_timeout();
        test_reset_mid_memrd();
        test_add();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_multicycle_control_fsm
`default_nettype wire
